// File: rtl/id_stage.sv
// Instruction-decode stage: holds the fetched instruction, reads and forwards
// the two source operands, resolves branches/jumps for IF, detects load-use
// hazards and raises SYSCALL/BREAK exceptions on the bundle sent to EXE.
// Bus widths: br_bus 35, fs_to_ds_bus 71, ds_to_es_bus 135.
module id_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         es_allowin,
  input  logic         fs_to_ds_valid,
  input  logic [70:0]  fs_to_ds_bus,
  output logic         ds_allowin,
  output logic [34:0]  br_bus,
  output logic         ds_to_es_valid,
  output logic [134:0] ds_to_es_bus,
  output logic [4:0]   rf_raddr1,
  output logic [4:0]   rf_raddr2,
  input  logic [31:0]  rf_rdata1,
  input  logic [31:0]  rf_rdata2,
  input  logic [38:0]  es_fwd_bus,
  input  logic [37:0]  ms_fwd_bus,
  input  logic [37:0]  ws_fwd_bus,
  input  logic         flush
);

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpRegimm  = 6'b000001;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpBne     = 6'b000101;
  localparam logic [5:0] OpBlez    = 6'b000110;
  localparam logic [5:0] OpBgtz    = 6'b000111;
  localparam logic [5:0] OpLui     = 6'b001111;
  localparam logic [5:0] OpCop0    = 6'b010000;

  localparam logic [5:0] FnSll     = 6'b000000;
  localparam logic [5:0] FnSrl     = 6'b000010;
  localparam logic [5:0] FnSra     = 6'b000011;
  localparam logic [5:0] FnJr      = 6'b001000;
  localparam logic [5:0] FnJalr    = 6'b001001;
  localparam logic [5:0] FnSyscall = 6'b001100;
  localparam logic [5:0] FnBreak   = 6'b001101;

  localparam logic [4:0] ExcSys    = 5'd8;
  localparam logic [4:0] ExcBp     = 5'd9;
  localparam logic [4:0] ExcNone   = 5'b11111;

  logic        ds_valid_q, ds_valid_d;
  logic [70:0] ds_bus_q, ds_bus_d;

  logic        in_ex, in_bd;
  logic [4:0]  in_exccode;
  logic [31:0] inst, pc, pc_plus4;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;

  assign {in_ex, in_exccode, in_bd, inst, pc} = ds_bus_q;
  assign op       = inst[31:26];
  assign funct    = inst[5:0];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign pc_plus4 = pc + 32'd4;

  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  // Forwarding bus fields
  logic        es_valid, es_is_load, ms_valid, ws_valid;
  logic [4:0]  es_dest, ms_dest, ws_dest;
  logic [31:0] es_result, ms_result, ws_result;

  assign {es_valid, es_is_load, es_dest, es_result} = es_fwd_bus;
  assign {ms_valid, ms_dest, ms_result}             = ms_fwd_bus;
  assign {ws_valid, ws_dest, ws_result}             = ws_fwd_bus;

  // dest == 0 means no write, so $0 sources can never hit
  logic es_hit_rs, es_hit_rt, ms_hit_rs, ms_hit_rt, ws_hit_rs, ws_hit_rt;
  assign es_hit_rs = es_valid && (es_dest != 5'd0) && (es_dest == rs);
  assign es_hit_rt = es_valid && (es_dest != 5'd0) && (es_dest == rt);
  assign ms_hit_rs = ms_valid && (ms_dest != 5'd0) && (ms_dest == rs);
  assign ms_hit_rt = ms_valid && (ms_dest != 5'd0) && (ms_dest == rt);
  assign ws_hit_rs = ws_valid && (ws_dest != 5'd0) && (ws_dest == rs);
  assign ws_hit_rt = ws_valid && (ws_dest != 5'd0) && (ws_dest == rt);

  logic [31:0] rs_value, rt_value;

  // Operand select: youngest producer wins
  always_comb begin
    rs_value = rf_rdata1;
    if (es_hit_rs)      rs_value = es_result;
    else if (ms_hit_rs) rs_value = ms_result;
    else if (ws_hit_rs) rs_value = ws_result;
    rt_value = rf_rdata2;
    if (es_hit_rt)      rt_value = es_result;
    else if (ms_hit_rt) rt_value = ms_result;
    else if (ws_hit_rt) rt_value = ws_result;
  end

  logic is_special, is_syscall, is_break, shift_imm;
  logic uses_rs, uses_rt;

  assign is_special = (op == OpSpecial);
  assign is_syscall = is_special && (funct == FnSyscall);
  assign is_break   = is_special && (funct == FnBreak);
  assign shift_imm  = is_special && (funct == FnSll || funct == FnSrl || funct == FnSra);

  assign uses_rs = !(op == OpJ || op == OpJal || op == OpLui || op == OpCop0 ||
                     shift_imm || is_syscall || is_break);
  // Stores are 101xxx; MTC0 is COP0 with rs field 00100
  assign uses_rt = (is_special && !is_syscall && !is_break) || op == OpBeq || op == OpBne ||
                   (op[5:3] == 3'b101) || (op == OpCop0 && rs == 5'b00100);

  logic load_use, ds_ready_go;
  assign load_use = ds_valid_q && es_is_load &&
                    ((uses_rs && es_hit_rs) || (uses_rt && es_hit_rt));
  assign ds_ready_go = ~load_use;

  assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid_q && ds_ready_go && ~flush;

  logic        br_op, br_cond;
  logic [31:0] br_tgt;
  logic        rs_neg, rs_zero;

  assign rs_neg  = rs_value[31];
  assign rs_zero = (rs_value == 32'd0);

  // Branch/jump decode, condition and target
  always_comb begin
    br_op   = 1'b0;
    br_cond = 1'b0;
    br_tgt  = pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00};
    case (op)
      OpBeq:  begin br_op = 1'b1; br_cond = (rs_value == rt_value); end
      OpBne:  begin br_op = 1'b1; br_cond = (rs_value != rt_value); end
      OpBlez: begin br_op = 1'b1; br_cond = rs_neg || rs_zero; end
      OpBgtz: begin br_op = 1'b1; br_cond = !rs_neg && !rs_zero; end
      OpRegimm: begin
        case (rt)
          5'b00000, 5'b10000: begin br_op = 1'b1; br_cond = rs_neg;  end
          5'b00001, 5'b10001: begin br_op = 1'b1; br_cond = !rs_neg; end
          default: ;
        endcase
      end
      OpJ, OpJal: begin
        br_op   = 1'b1;
        br_cond = 1'b1;
        br_tgt  = {pc_plus4[31:28], inst[25:0], 2'b00};
      end
      OpSpecial: begin
        if (funct == FnJr || funct == FnJalr) begin
          br_op   = 1'b1;
          br_cond = 1'b1;
          br_tgt  = rs_value;
        end
      end
      default: ;
    endcase
  end

  logic is_branch, br_taken, br_stall;
  // Excepting instructions never redirect; flush kills the redirect too
  assign is_branch = ds_valid_q && br_op && ~in_ex && ~flush;
  assign br_taken  = is_branch && br_cond && ds_ready_go;
  assign br_stall  = is_branch && load_use;
  assign br_bus    = {is_branch, br_stall, br_taken, is_branch ? br_tgt : 32'd0};

  logic       ex_out;
  logic [4:0] exccode_out;

  // Exception merge: an earlier exception from IF takes priority
  always_comb begin
    ex_out      = 1'b0;
    exccode_out = ExcNone;
    if (in_ex) begin
      ex_out      = 1'b1;
      exccode_out = in_exccode;
    end else if (is_syscall) begin
      ex_out      = 1'b1;
      exccode_out = ExcSys;
    end else if (is_break) begin
      ex_out      = 1'b1;
      exccode_out = ExcBp;
    end
  end

  assign ds_to_es_bus = {ex_out, exccode_out, in_bd, inst, pc, rs_value, rt_value};

  // Pipeline register next state: flush kills, otherwise load when allowed
  always_comb begin
    ds_valid_d = ds_valid_q;
    ds_bus_d   = ds_bus_q;
    if (flush) begin
      ds_valid_d = 1'b0;
    end else if (ds_allowin) begin
      ds_valid_d = fs_to_ds_valid;
      if (fs_to_ds_valid) ds_bus_d = fs_to_ds_bus;
    end
  end

  // Pipeline register state
  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      ds_bus_q   <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      ds_bus_q   <= ds_bus_d;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic, all checked
// against a behavioural model of the decode stage.
module tb_id_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_allowin;
  logic         fs_to_ds_valid;
  logic [70:0]  fs_to_ds_bus;
  logic         ds_allowin;
  logic [34:0]  br_bus;
  logic         ds_to_es_valid;
  logic [134:0] ds_to_es_bus;
  logic [4:0]   rf_raddr1, rf_raddr2;
  logic [31:0]  rf_rdata1, rf_rdata2;
  logic [38:0]  es_fwd_bus;
  logic [37:0]  ms_fwd_bus, ws_fwd_bus;
  logic         flush;

  logic [31:0]  regs [32];

  int total = 0;
  int bad   = 0;

  // Model state
  logic         m_valid = 1'b0;
  logic [70:0]  m_bus   = '0;
  logic         e_allowin = 1'b1;

  always #5 clk = ~clk;

  assign rf_rdata1 = regs[rf_raddr1];
  assign rf_rdata2 = regs[rf_raddr2];

  id_stage dut (
    .clk            (clk),
    .reset          (reset),
    .es_allowin     (es_allowin),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_allowin     (ds_allowin),
    .br_bus         (br_bus),
    .ds_to_es_valid (ds_to_es_valid),
    .ds_to_es_bus   (ds_to_es_bus),
    .rf_raddr1      (rf_raddr1),
    .rf_raddr2      (rf_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .es_fwd_bus     (es_fwd_bus),
    .ms_fwd_bus     (ms_fwd_bus),
    .ws_fwd_bus     (ws_fwd_bus),
    .flush          (flush)
  );

  task automatic check(input string tag, input logic [134:0] got, input logic [134:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit es_match(input logic [4:0] r);
    return es_fwd_bus[38] && es_fwd_bus[36:32] != 5'd0 && es_fwd_bus[36:32] == r;
  endfunction

  function automatic logic [31:0] fwd_val(input logic [4:0] r);
    if (es_match(r)) return es_fwd_bus[31:0];
    if (ms_fwd_bus[37] && ms_fwd_bus[36:32] != 5'd0 && ms_fwd_bus[36:32] == r)
      return ms_fwd_bus[31:0];
    if (ws_fwd_bus[37] && ws_fwd_bus[36:32] != 5'd0 && ws_fwd_bus[36:32] == r)
      return ws_fwd_bus[31:0];
    return regs[r];
  endfunction

  // Evaluate the model against the held instruction and compare all outputs
  task automatic compare();
    logic [31:0] inst, pc, rsv, rtv, tgt, pc4;
    logic [4:0]  rs, rt, code;
    int          op, fn;
    bit          uses_rs, uses_rt, lu, br, cond, isb, ex, esv;
    inst = m_bus[63:32];
    pc   = m_bus[31:0];
    pc4  = pc + 32'd4;
    op   = int'(inst[31:26]);
    fn   = int'(inst[5:0]);
    rs   = inst[25:21];
    rt   = inst[20:16];
    rsv  = fwd_val(rs);
    rtv  = fwd_val(rt);
    uses_rs = !(op == 2 || op == 3 || op == 15 || op == 16 ||
                (op == 0 && (fn == 0 || fn == 2 || fn == 3 || fn == 12 || fn == 13)));
    uses_rt = (op == 0 && fn != 12 && fn != 13) || op == 4 || op == 5 ||
              (op >= 40 && op <= 47) || (op == 16 && rs == 5'd4);
    lu = m_valid && es_fwd_bus[37] && ((uses_rs && es_match(rs)) || (uses_rt && es_match(rt)));
    br   = 1'b0;
    cond = 1'b0;
    tgt  = pc4 + 32'($signed(inst[15:0])) * 4;
    if (op == 4)                   begin br = 1; cond = (rsv == rtv); end
    else if (op == 5)              begin br = 1; cond = (rsv != rtv); end
    else if (op == 6)              begin br = 1; cond = ($signed(rsv) <= 0); end
    else if (op == 7)              begin br = 1; cond = ($signed(rsv) > 0); end
    else if (op == 1 && (rt == 0 || rt == 16)) begin br = 1; cond = ($signed(rsv) < 0); end
    else if (op == 1 && (rt == 1 || rt == 17)) begin br = 1; cond = ($signed(rsv) >= 0); end
    else if (op == 2 || op == 3) begin
      br = 1; cond = 1;
      tgt = {pc4[31:28], inst[25:0], 2'b00};
    end else if (op == 0 && (fn == 8 || fn == 9)) begin
      br = 1; cond = 1; tgt = rsv;
    end
    if (m_bus[70])              begin ex = 1; code = m_bus[69:65]; end
    else if (op == 0 && fn == 12) begin ex = 1; code = 5'd8; end
    else if (op == 0 && fn == 13) begin ex = 1; code = 5'd9; end
    else                        begin ex = 0; code = 5'd31; end
    isb       = m_valid && br && !m_bus[70] && !flush;
    esv       = m_valid && !lu && !flush;
    e_allowin = !m_valid || (!lu && es_allowin);
    check("ds_allowin", 135'(ds_allowin), 135'(e_allowin));
    check("ds_to_es_valid", 135'(ds_to_es_valid), 135'(esv));
    check("br_flags", 135'(br_bus[34:32]), 135'({isb, isb && lu, isb && cond && !lu}));
    if (isb) check("br_target", 135'(br_bus[31:0]), 135'(tgt));
    if (!m_valid || flush) check("br_bus_zero", 135'(br_bus), 135'(0));
    if (m_valid) check("rf_raddr", 135'({rf_raddr1, rf_raddr2}), 135'({rs, rt}));
    if (esv) check("ds_to_es_bus", ds_to_es_bus, {ex, code, m_bus[64], inst, pc, rsv, rtv});
  endtask

  // Inputs are driven 1ns after the edge; settle samples at the falling edge
  task automatic settle();
    #4;
    compare();
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset || flush) m_valid = 1'b0;
    else if (e_allowin) begin
      m_valid = fs_to_ds_valid;
      if (fs_to_ds_valid) m_bus = fs_to_ds_bus;
    end
    #1;
  endtask

  task automatic clear_fwd();
    es_fwd_bus = '0;
    ms_fwd_bus = '0;
    ws_fwd_bus = '0;
  endtask

  // Present one instruction for a cycle, then stop offering
  task automatic load(input logic [31:0] inst, input logic [31:0] pc);
    clear_fwd();
    es_allowin     = 1'b1;
    flush          = 1'b0;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {1'b0, 5'h1f, 1'b0, inst, pc};
    settle();
    advance();
    fs_to_ds_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hffff_ffff;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [4:0]  sel [4];
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 31));
    imm = 16'($urandom());
    sel = '{5'd0, 5'd1, 5'd16, 5'd17};
    case ($urandom_range(0, 16))
      0:  return {6'd0, rs, rt, rd, 5'd0, 6'h21};
      1:  return {6'd0, 5'd0, rt, rd, 5'($urandom()), 6'h00};
      2:  return {6'd0, rs, 15'd0, 6'h08};
      3:  return {6'd0, rs, 5'd0, 5'd31, 5'd0, 6'h09};
      4:  return {6'd0, 20'($urandom()), 6'h0c};
      5:  return {6'd0, 20'($urandom()), 6'h0d};
      6:  return {6'd4, rs, rt, imm};
      7:  return {6'd5, rs, rt, imm};
      8:  return {6'd6, rs, 5'd0, imm};
      9:  return {6'd7, rs, 5'd0, imm};
      10: return {6'd1, rs, sel[$urandom_range(0, 3)], imm};
      11: return {6'd2, 26'($urandom())};
      12: return {6'd3, 26'($urandom())};
      13: return {6'd15, 5'd0, rt, imm};
      14: return {6'd43, rs, rt, imm};
      15: return {6'd16, ($urandom_range(0, 1) == 1) ? 5'd4 : 5'd0, rt, rd, 11'd0};
      default: return {6'd35, rs, rt, imm};
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    reset          = 1'b1;
    es_allowin     = 1'b1;
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus   = '0;
    flush          = 1'b0;
    clear_fwd();
    @(posedge clk);
    #1;
    advance();
    settle();
    check("rst_allowin", 135'(ds_allowin), 135'(1));
    check("rst_es_valid", 135'(ds_to_es_valid), 135'(0));
    check("rst_br_bus", 135'(br_bus), 135'(0));
    advance();
    reset = 1'b0;

    // ADDU $3,$1,$2 with plain register-file operands
    regs[1] = 32'd5;
    regs[2] = 32'd7;
    load({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'hbfc0_0000);
    settle();
    check("addu_valid", 135'(ds_to_es_valid), 135'(1));
    check("addu_ops", 135'(ds_to_es_bus[63:0]), 135'({32'd5, 32'd7}));
    advance();

    // Forwarding priority EXE over MEM, then MEM once EXE retargets to $0
    load({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 32'hbfc0_0004);
    es_allowin = 1'b0;
    es_fwd_bus = {1'b1, 1'b0, 5'd1, 32'h11};
    ms_fwd_bus = {1'b1, 5'd1, 32'h22};
    settle();
    check("fwd_exe", 135'(ds_to_es_bus[63:32]), 135'(32'h11));
    advance();
    es_fwd_bus = {1'b1, 1'b0, 5'd0, 32'h11};
    settle();
    check("fwd_mem", 135'(ds_to_es_bus[63:32]), 135'(32'h22));
    advance();

    // BEQ $1,$2 taken, forward and backward offsets
    regs[1] = 32'd9;
    regs[2] = 32'd9;
    load({6'd4, 5'd1, 5'd2, 16'h0003}, 32'hbfc0_0010);
    settle();
    check("beq_fwd", 135'(br_bus), 135'({1'b1, 1'b0, 1'b1, 32'hbfc0_0020}));
    advance();
    load({6'd4, 5'd1, 5'd2, 16'hffff}, 32'hbfc0_0010);
    settle();
    check("beq_back", 135'(br_bus), 135'({1'b1, 1'b0, 1'b1, 32'hbfc0_0010}));
    advance();

    // Load-use on BNE $4,$0: one stall cycle, then MEM forwards
    load({6'd5, 5'd4, 5'd0, 16'h0002}, 32'hbfc0_0040);
    es_fwd_bus = {1'b1, 1'b1, 5'd4, 32'h55};
    settle();
    check("lu_stall", 135'(br_bus[34:32]), 135'(3'b110));
    check("lu_es_valid", 135'(ds_to_es_valid), 135'(0));
    advance();
    es_fwd_bus = '0;
    ms_fwd_bus = {1'b1, 5'd4, 32'h55};
    settle();
    check("lu_resolve", 135'(br_bus), 135'({1'b1, 1'b0, 1'b1, 32'hbfc0_004c}));
    check("lu_go", 135'(ds_to_es_valid), 135'(1));
    advance();

    // SYSCALL with a simultaneous flush
    load({6'd0, 20'd0, 6'h0c}, 32'hbfc0_0080);
    flush = 1'b1;
    settle();
    check("sys_exc", 135'(ds_to_es_bus[134:129]), 135'({1'b1, 5'd8}));
    check("sys_flush_valid", 135'(ds_to_es_valid), 135'(0));
    advance();
    flush = 1'b0;
    settle();
    check("post_flush_valid", 135'(ds_to_es_valid), 135'(0));
    check("post_flush_br", 135'(br_bus), 135'(0));
    advance();

    // JR $31 held by EXE backpressure for three cycles
    regs[31] = 32'hbfc0_0100;
    load({6'd0, 5'd31, 15'd0, 6'h08}, 32'hbfc0_00c0);
    es_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("jr_hold_allowin", 135'(ds_allowin), 135'(0));
      check("jr_hold_br", 135'(br_bus), 135'({1'b1, 1'b0, 1'b1, 32'hbfc0_0100}));
      advance();
    end
    es_allowin = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      for (int i = 1; i < 32; i++) regs[i] = rand_val();
      es_fwd_bus     = {1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                        5'($urandom_range(0, 7)), rand_val()};
      ms_fwd_bus     = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), rand_val()};
      ws_fwd_bus     = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), rand_val()};
      es_allowin     = ($urandom_range(0, 3) != 0);
      fs_to_ds_valid = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 15) == 0);
      reset          = ($urandom_range(0, 63) == 0);
      fs_to_ds_bus   = {($urandom_range(0, 9) == 0), 5'($urandom()), 1'($urandom()),
                        rand_inst(), $urandom() & 32'hffff_fffc};
      settle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
